// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: decodes the BASE window of the PicoSoC iomem port onto NSLAVES slave slots.
// Latency: 2 cycles minimum for a mapped access, 1 cycle for an unmapped one, TIMEOUT+1 for a hung slave.
// Backpressure: one transaction at a time; s_valid is held until the slave handshakes or the timeout expires.
module iomem_bus_ctrl #(
  parameter int          NSLAVES  = 4,
  parameter logic [7:0]  BASE     = 8'h03,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iomem_valid,
  output logic                    iomem_ready,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic [31:0]             iomem_rdata,
  output logic [NSLAVES-1:0]      s_valid,
  input  logic [NSLAVES-1:0]      s_ready,
  output logic [3:0]              s_wstrb,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  input  logic [32*NSLAVES-1:0]   s_rdata,
  output logic                    bus_err,
  output logic [15:0]             err_count,
  output logic [31:0]             err_addr
);

  // Counter only needs to reach TIMEOUT-1; it fires on the cycle it would reach TIMEOUT.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic [7:0]          slot;
  logic [CW-1:0]       tcnt;
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic [NSLAVES-1:0]  onehot_in;
  logic                accept;
  logic                mapped_in;

  // Incoming request is ours only when the top byte matches and it is not the one just answered.
  assign accept    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE);
  assign mapped_in = ({24'd0, iomem_addr[23:16]} < 32'(NSLAVES));

  // Pick the handshake and read data of the latched slot; other slots are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (slot == 8'(k)) begin
        sel_ready = s_ready[k];
        sel_rdata = s_rdata[32*k +: 32];
      end
    end
  end

  // One-hot request vector for the slot addressed by the incoming request.
  always_comb begin
    onehot_in = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      onehot_in[k] = (iomem_addr[23:16] == 8'(k));
    end
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequencer: IDLE accepts, ACCESS waits for the slave or the timeout, RESP answers the SoC once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      slot        <= '0;
      tcnt        <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      s_valid     <= '0;
      s_wstrb     <= '0;
      s_addr      <= '0;
      s_wdata     <= '0;
      bus_err     <= 1'b0;
      err_count   <= '0;
      err_addr    <= '0;
    end else begin
      iomem_ready <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            s_addr  <= iomem_addr;
            s_wstrb <= iomem_wstrb;
            s_wdata <= iomem_wdata;
            slot    <= iomem_addr[23:16];
            if (mapped_in) begin
              s_valid <= onehot_in;
              tcnt    <= '0;
              state   <= ACCESS;
            end else begin
              iomem_rdata <= ERR_DATA;
              iomem_ready <= 1'b1;
              bus_err     <= 1'b1;
              err_count   <= sat_inc(err_count);
              err_addr    <= iomem_addr;
              state       <= RESP;
            end
          end
        end
        ACCESS: begin
          // A handshake in the expiry cycle still completes normally.
          if (sel_ready) begin
            iomem_rdata <= sel_rdata;
            iomem_ready <= 1'b1;
            s_valid     <= '0;
            state       <= RESP;
          end else if ((TIMEOUT != 0) && (tcnt == TO_LAST)) begin
            iomem_rdata <= ERR_DATA;
            iomem_ready <= 1'b1;
            bus_err     <= 1'b1;
            err_count   <= sat_inc(err_count);
            err_addr    <= s_addr;
            s_valid     <= '0;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          s_valid <= '0;
        end
      endcase
    end
  end

endmodule
